// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: payload+valid pipeline register with stall-vector (MODE=0) or
// valid/ready 2-entry skid (MODE=1) control, flush, and saturating counters.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int STALL_W = 6,
    parameter int STAGE = 2,
    parameter int MODE = 0,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              stall_me, stall_next, hold_inc, bubble_inc;

    assign stall_me   = stall[STAGE];
    assign stall_next = stall[STAGE+1];
    assign in_ready   = (MODE == 0) ? ~stall_me : ~skid_valid;
    assign hold_inc   = (MODE == 0) ? ~flush & stall_me & stall_next : out_valid & ~out_ready;
    assign bubble_inc = (MODE == 0) ? ~flush & stall_me & ~stall_next : ~out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= BUBBLE_VAL;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE_VAL;
            hold_cnt   <= '0;
            bubble_cnt <= '0;
        end else begin
            if (hold_inc && hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
            if (bubble_inc && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (flush) begin
                out_data   <= BUBBLE_VAL;
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (MODE == 0) begin
                // hold (both stalled) keeps out_data/out_valid untouched
                if (stall_me && !stall_next) begin
                    out_data  <= BUBBLE_VAL;
                    out_valid <= 1'b0;
                end else if (!stall_me) begin
                    out_data  <= in_data;
                    out_valid <= in_valid;
                end
            end else if (!out_valid || out_ready) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_data  <= in_data;
                    out_valid <= in_valid & in_ready;
                end
            end else if (in_valid && in_ready) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of stall-vector mode, skid mode and counter saturation.
module tb_pipe_stage_reg;
    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [5:0] stall;
    logic [7:0] in_data;
    logic       r0, v0, r1, v1, r2, v2;
    logic [7:0] d0, d1, d2;
    logic [15:0] h0, b0, h1, b1;
    logic [1:0] h2, b2;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(8), .MODE(0), .BUBBLE_VAL(8'hEE)) u0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_ready(r0),
        .in_data(in_data), .out_valid(v0), .out_ready(out_ready), .out_data(d0),
        .hold_cnt(h0), .bubble_cnt(b0));
    pipe_stage_reg #(.DATA_W(8), .MODE(1), .BUBBLE_VAL(8'hEE)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .hold_cnt(h1), .bubble_cnt(b1));
    pipe_stage_reg #(.DATA_W(8), .MODE(0), .BUBBLE_VAL(8'hEE), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_ready(r2),
        .in_data(in_data), .out_valid(v2), .out_ready(out_ready), .out_data(d2),
        .hold_cnt(h2), .bubble_cnt(b2));

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall = '0; in_data = '0;
        step(2);
        rst = 1'b0;
        check("rst_d0", 32'(d0), 32'hEE);
        check("rst_v0", 32'(v0), 0);
        check("rst_h0", 32'(h0), 0);
        check("rst_b0", 32'(b0), 0);
        check("rst_r1", 32'(r1), 1);
        check("rst_v1", 32'(v1), 0);
        // MODE=0 advance
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        check("adv_d0", 32'(d0), 32'hA5);
        check("adv_v0", 32'(v0), 1);
        check("adv_cnt0", 32'({h0, b0}), 0);
        in_valid = 1'b0;
        step();
        check("adv_nv_v0", 32'(v0), 0);
        // MODE=0 bubble, then saturation on the CNT_W=2 copy
        stall = 6'b000100; in_valid = 1'b1; in_data = 8'h5A;
        #1 check("bub_r0", 32'(r0), 0);
        step(3);
        check("bub_d0", 32'(d0), 32'hEE);
        check("bub_v0", 32'(v0), 0);
        check("bub_b0_3", 32'(b0), 3);
        step(3);
        check("bub_b0_6", 32'(b0), 6);
        check("sat_b2", 32'(b2), 3);
        // MODE=0 hold
        stall = '0; in_data = 8'h11;
        step();
        check("hold_pre_d0", 32'(d0), 32'h11);
        stall = 6'b001100; in_data = 8'h22;
        step(4);
        check("hold_d0", 32'(d0), 32'h11);
        check("hold_v0", 32'(v0), 1);
        check("hold_h0", 32'(h0), 4);
        check("sat_h2", 32'(h2), 3);
        stall = '0;
        step();
        check("hold_rel_d0", 32'(d0), 32'h22);
        // flush beats bubble and leaves counters alone
        stall = 6'b000100; flush = 1'b1;
        step();
        flush = 1'b0; stall = '0;
        check("fl0_d0", 32'(d0), 32'hEE);
        check("fl0_v0", 32'(v0), 0);
        check("fl0_b0", 32'(b0), 6);
        in_data = 8'h33;
        step();
        check("pre_rst_d0", 32'(d0), 32'h33);
        // reset mid-stream
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_d0", 32'(d0), 32'hEE);
        check("mrst_v0", 32'(v0), 0);
        check("mrst_cnt0", 32'({h0, b0}), 0);
        check("mrst_cnt2", 32'({h2, b2}), 0);
        check("mrst_d2", 32'(d2), 32'hEE);
        // MODE=1 skid streaming; stall vector must be ignored
        stall = 6'b001100; in_valid = 1'b1; in_data = 8'd1; out_ready = 1'b1;
        step();
        check("sk1_d1", 32'(d1), 1);
        check("sk1_v1", 32'(v1), 1);
        in_data = 8'd2; out_ready = 1'b0;
        step();
        check("sk2_d1", 32'(d1), 1);
        check("sk2_r1", 32'(r1), 0);
        in_data = 8'd3;
        step();
        check("sk3_d1", 32'(d1), 1);
        check("sk3_r1", 32'(r1), 0);
        out_ready = 1'b1;
        step();
        check("sk4_d1", 32'(d1), 2);
        check("sk4_r1", 32'(r1), 1);
        step();
        check("sk5_d1", 32'(d1), 3);
        in_data = 8'd4;
        step();
        check("sk6_d1", 32'(d1), 4);
        check("sk6_v1", 32'(v1), 1);
        in_valid = 1'b0;
        step();
        check("sk7_v1", 32'(v1), 0);
        check("sk_h1", 32'(h1), 2);
        check("sk_b1", 32'(b1), 1);
        // MODE=1 flush with out and skid full
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        step();
        in_data = 8'h66;
        step();
        check("fl1_pre_d1", 32'(d1), 32'h55);
        check("fl1_pre_r1", 32'(r1), 0);
        flush = 1'b1; in_data = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl1_v1", 32'(v1), 0);
        check("fl1_r1", 32'(r1), 1);
        check("fl1_d1", 32'(d1), 32'hEE);
        step();
        check("fl1_post_v1", 32'(v1), 0);
        step();
        check("fl1_post2_v1", 32'(v1), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the general successor of the fixed ID/EX latch. It carries an opaque DATA_W payload plus a valid bit between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It has two modes:
- MODE=0: legacy stall-vector control, with a corrected hold case.
- MODE=1: valid/ready handshake with a 2-entry skid buffer.

Both modes support flush and provide saturating hold and bubble performance counters.

Parameters:
DATA_W, 64, payload width in bits (packed control and operand fields).
STALL_W, 6, width of the stall vector.
STAGE, 2, index of this stage's bit in stall; must satisfy STAGE+1 < STALL_W.
MODE, 0, 0 = stall-vector mode, 1 = valid/ready skid mode.
BUBBLE_VAL, 0, payload driven on out_data when a bubble is inserted or on reset/flush (NoAlu/NoJump/NoBranch encoding).
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  STALL_W  per-stage stall vector from the stall controller (MODE=0 only).
flush  in  1  kill in-flight contents (branch mispredict or jump redirect).
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept the payload this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  downstream payload valid.
out_ready  in  1  downstream accepts the payload (MODE=1 only).
out_data  out  DATA_W  registered payload to the next stage.
hold_cnt  out  CNT_W  cycles the stage held its contents.
bubble_cnt  out  CNT_W  bubbles inserted (MODE=0) or empty-output cycles while downstream was ready (MODE=1).

Behaviour:
Reset (rst=1 at posedge):
- out_data=BUBBLE_VAL, out_valid=0.
- Skid register cleared: skid_valid=0, skid_data=BUBBLE_VAL.
- hold_cnt=0, bubble_cnt=0.
- Reset overrides every other input, including mid-transfer; all contents are lost.

Counters:
- Saturate at all-ones and never wrap.
- Not cleared by flush.

MODE=0. Priority at each posedge is rst > flush > bubble > hold > advance.
- in_ready = ~stall[STAGE] (combinational). out_ready is ignored. Skid is unused and stays 0.
- flush: out_data<=BUBBLE_VAL, out_valid<=0. No counter change.
- bubble, when stall[STAGE] & ~stall[STAGE+1]: out_data<=BUBBLE_VAL, out_valid<=0, bubble_cnt++.
- hold, when stall[STAGE] & stall[STAGE+1]: out_data and out_valid unchanged, hold_cnt++.
- advance, otherwise: out_data<=in_data, out_valid<=in_valid.
- Latency is 1 cycle.

MODE=1. The stall vector is ignored.
- in_ready = ~skid_valid. It is a registered bit with no combinational path from out_ready.
- Downstream transfer: out_valid & out_ready. Upstream transfer: in_valid & in_ready.
- When the output is free (~out_valid | out_ready):
  - skid_valid=1: out_data<=skid_data, out_valid<=1, skid_valid<=0.
  - Otherwise: out_data<=in_data, out_valid<=in_valid & in_ready.
- When the output is blocked (out_valid & ~out_ready):
  - An upstream transfer writes in_data into skid_data and sets skid_valid<=1.
  - out_data and out_valid are unchanged.
- Ordering is preserved and no payload is lost or duplicated. At most 2 payloads are in flight.
- Throughput is 1 per cycle when out_ready is held high. Latency is 1 cycle.
- flush: out_valid<=0, skid_valid<=0, out_data<=BUBBLE_VAL. Any upstream transfer in the same cycle is discarded.
- hold_cnt++ on each cycle with out_valid & ~out_ready.
- bubble_cnt++ on each cycle with ~out_valid & out_ready.

Simultaneous flush and stall (either mode): flush wins.

Test Plan:
- MODE=0, stall=0, in_data=0xA5 and valid held for 1 cycle → next cycle out_data=0xA5, out_valid=1; counters stay 0.
- MODE=0, STAGE=2, stall=6'b000100 for 3 cycles → out_data=BUBBLE_VAL, out_valid=0, bubble_cnt=3, in_ready=0.
- MODE=0, out holds 0x11, stall=6'b001100 for 4 cycles while in_data=0x22 → out_data stays 0x11, hold_cnt=4; after stall drops → out_data=0x22.
- MODE=1, in_valid=1 streaming 1,2,3,4; out_ready=0 for cycles 2–3, then 1 → output sequence exactly 1,2,3,4; in_ready=0 while the skid is full; hold_cnt=2.
- MODE=1, skid and out both full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed payloads never appear on the output.
- CNT_W=2, MODE=0, bubble condition held for 6 cycles → bubble_cnt=3 (saturated); rst mid-stream → every output returns to its reset value the next cycle.
